// File: rtl/cmp_seq_ctrl.sv
// Wide unsigned compare built from one N-bit slice comparator, scanned MSB slice first.
// Build option: define EARLY_EXIT_EN to stop the scan at the first differing slice.
module cmp_seq_ctrl #(
  parameter int unsigned N      = 4,
  parameter int unsigned SLICES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N*SLICES-1:0]          A,
  input  logic [N*SLICES-1:0]          B,
  output logic                         busy,
  output logic                         done,
  output logic                         equal,
  output logic                         A_greater_than_B,
  output logic                         B_greater_than_A,
  output logic [$clog2(SLICES+1)-1:0]  slices_used
);

  localparam int unsigned W    = N * SLICES;
  localparam int unsigned IdxW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned CntW = $clog2(SLICES + 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e            state_q;
  logic [W-1:0]      a_q, b_q;
  logic [IdxW-1:0]   idx_q;
  logic              dec_q;
  logic              gt_q;

  logic [N-1:0]      slice_a, slice_b;
  logic              slice_diff, slice_gt, terminal;
  logic [CntW-1:0]   slices_cnt;
  int unsigned       base;

  // The single shared slice comparator.
  always_comb begin
    base       = 32'(idx_q) * N;
    slice_a    = a_q[base +: N];
    slice_b    = b_q[base +: N];
    slice_diff = (slice_a != slice_b);
    slice_gt   = (slice_a > slice_b);
    slices_cnt = CntW'(SLICES) - CntW'(idx_q);
  end

`ifdef EARLY_EXIT_EN
  assign terminal = (idx_q == '0) || slice_diff;
`else
  assign terminal = (idx_q == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      a_q              <= '0;
      b_q              <= '0;
      idx_q            <= '0;
      dec_q            <= 1'b0;
      gt_q             <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      equal            <= 1'b0;
      A_greater_than_B <= 1'b0;
      B_greater_than_A <= 1'b0;
      slices_used      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            idx_q   <= IdxW'(SLICES - 1);
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            busy    <= 1'b1;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (!dec_q && slice_diff) begin
            dec_q <= 1'b1;
            gt_q  <= slice_gt;
          end
          if (terminal) begin
            // A slice decided earlier overrides whatever the current slice says.
            equal            <= !dec_q && !slice_diff;
            A_greater_than_B <= dec_q ? gt_q  : (slice_diff && slice_gt);
            B_greater_than_A <= dec_q ? !gt_q : (slice_diff && !slice_gt);
            slices_used      <= slices_cnt;
            done             <= 1'b1;
            busy             <= 1'b0;
            state_q          <= StIdle;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed, table-driven bench for cmp_seq_ctrl (N=4, SLICES=4), plus multi-cycle corner sequences.
module tb_cmp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, done, equal, A_greater_than_B, B_greater_than_A;
  logic [2:0]  slices_used;

  int checks   = 0;
  int failures = 0;

  cmp_seq_ctrl #(.N(4), .SLICES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .A                (A),
    .B                (B),
    .busy             (busy),
    .done             (done),
    .equal            (equal),
    .A_greater_than_B (A_greater_than_B),
    .B_greater_than_A (B_greater_than_A),
    .slices_used      (slices_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        eq;
    logic        agt;
    logic        bgt;
    int          lat_early;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int lat_early);
`ifdef EARLY_EXIT_EN
    return lat_early;
`else
    return 4;
`endif
  endfunction

  // Waits for done after the start edge; lat is the negedge count after edge 0 (0 = timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_cmp(input logic [15:0] a, input logic [15:0] b, output int lat,
                        output logic busy_after);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_after = busy;
    if (done) lat = 0;
    else wait_done(lat);
  endtask

  initial begin
    int          lat;
    logic        b_after;
    int          dones;
    logic        held;

    vecs[0] = '{16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b0, 4};
    vecs[1] = '{16'h9000, 16'h8FFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{16'h1233, 16'h1234, 1'b0, 1'b0, 1'b1, 4};
    vecs[3] = '{16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 4};
    vecs[4] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[5] = '{16'h12A4, 16'h1234, 1'b0, 1'b1, 1'b0, 3};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4};
    vecs[7] = '{16'h0F00, 16'h1000, 1'b0, 1'b0, 1'b1, 1};

    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_flags", {29'd0, equal, A_greater_than_B, B_greater_than_A}, 0);
    chk("reset_used", 32'(slices_used), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven compares.
    for (int v = 0; v < 8; v++) begin
      do_cmp(vecs[v].a, vecs[v].b, lat, b_after);
      chk($sformatf("v%0d_busy_after_start", v), 32'(b_after), 1);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(exp_lat(vecs[v].lat_early)));
      chk($sformatf("v%0d_busy_at_done", v), 32'(busy), 0);
      chk($sformatf("v%0d_flags", v), {29'd0, equal, A_greater_than_B, B_greater_than_A},
          {29'd0, vecs[v].eq, vecs[v].agt, vecs[v].bgt});
      chk($sformatf("v%0d_used", v), 32'(slices_used), 32'(exp_lat(vecs[v].lat_early)));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", v), 32'(done), 0);
    end

    // Back-to-back: start held through the done cycle with new operands.
    @(negedge clk);
    A = 16'hBEEF; B = 16'hBEEF; start = 1'b1;
    @(negedge clk);
    wait_done(lat);
    chk("b2b_first_latency", 32'(lat), 4);
    chk("b2b_first_eq", 32'(equal), 1);
    A = 16'h0001; B = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_bubble_busy", 32'(busy), 1);
    chk("b2b_hold_eq_midscan", 32'(equal), 1);
    wait_done(lat);
    chk("b2b_second_latency", 32'(lat), 4);
    chk("b2b_second_flags", {29'd0, equal, A_greater_than_B, B_greater_than_A}, 32'b010);
    chk("b2b_second_used", 32'(slices_used), 4);

    // start toggled and operands changed while busy.
    @(negedge clk);
    A = 16'h1233; B = 16'h1234; start = 1'b1;
    @(negedge clk);
    dones = 0;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      if (busy && !A_greater_than_B) held = 1'b0;
      A = 16'hFFFF; B = 16'h0000;
      start = busy ? ~start : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("tog_done_count", 32'(dones), 1);
    chk("tog_flags_held_midscan", 32'(held), 1);
    chk("tog_flags", {29'd0, equal, A_greater_than_B, B_greater_than_A}, 32'b001);
    chk("tog_idle", 32'(busy), 0);

    // Reset asserted mid-scan, after scan edge 1.
    @(negedge clk);
    A = 16'h1233; B = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_flags", {29'd0, equal, A_greater_than_B, B_greater_than_A}, 0);
    chk("rst_mid_used", 32'(slices_used), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("rst_mid_no_done", 32'(dones), 0);
    do_cmp(16'h0001, 16'h0000, lat, b_after);
    chk("rst_fresh_latency", 32'(lat), 4);
    chk("rst_fresh_flags", {29'd0, equal, A_greater_than_B, B_greater_than_A}, 32'b010);
    chk("rst_fresh_used", 32'(slices_used), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
